serial_pattern_tx: RTL

- Transmitter counterpart of the team's serial sequence detector.
- Accepts a parallel word through a valid/ready handshake, then drives it MSB-first onto a single-bit serial line, one bit per clock.
- After each frame it inserts a fixed idle gap. It also keeps a wrapping frame counter.
- Sits upstream of the detector and drives the detector's `in` directly, both in the system and in benches.

---
 rtl/serial_pattern_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel word in, MSB-first serial line out.
// Inserts a fixed idle gap after each frame and counts completed frames.
module serial_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       frame_count
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [3:0]       gapcnt, gapcnt_n;
    logic             out_n, out_valid_n, busy_n, done_n;
    logic [7:0]       fc_n;
    logic             fin;

    assign in_ready = (state == S_IDLE);

    // next-state and next-output decode
    always_comb begin
        state_n     = state;
        sh_n        = sh;
        bitcnt_n    = bitcnt;
        gapcnt_n    = gapcnt;
        out_n       = out;
        out_valid_n = out_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        fc_n        = frame_count;
        fin         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    sh_n        = data;
                    out_n       = data[WIDTH-1];
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    bitcnt_n    = CW'(1);
                    state_n     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bitcnt == CW'(WIDTH)) begin
                    out_n       = IDLE_LEVEL;
                    out_valid_n = 1'b0;
                    if (GAP > 0) begin
                        gapcnt_n = 4'(GAP);
                        state_n  = S_GAP;
                    end else begin
                        fin = 1'b1;
                    end
                end else begin
                    sh_n     = sh << 1;
                    out_n    = sh[WIDTH-2];
                    bitcnt_n = bitcnt + CW'(1);
                end
            end
            S_GAP: begin
                if (gapcnt == 4'd1) begin
                    fin = 1'b1;
                end else begin
                    gapcnt_n = gapcnt - 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // frame plus gap complete: back to idle, pulse done, count it
        if (fin) begin
            state_n  = S_IDLE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            bitcnt_n = '0;
            gapcnt_n = '0;
            fc_n     = frame_count + 8'd1;
        end
    end

    // state and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sh          <= '0;
            bitcnt      <= '0;
            gapcnt      <= '0;
            out         <= IDLE_LEVEL;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            bitcnt      <= bitcnt_n;
            gapcnt      <= gapcnt_n;
            out         <= out_n;
            out_valid   <= out_valid_n;
            busy        <= busy_n;
            done        <= done_n;
            frame_count <= fc_n;
        end
    end

endmodule
